// File: rtl/memory_key_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : memory_key_controller
// Purpose  : Result-memory sequencer for the calculator. Synchronises and
//            debounces two user keys, classifies each press as short or long,
//            and drives a small bank of result slots:
//              key0 short -> save current_result into the active slot
//                            (deferred while the ALU is busy)
//              key0 long  -> clear every slot
//              key1 short -> recall the active slot
//              key1 long  -> advance to the next slot and recall it
// Ports    : clk, reset          clock, asynchronous active-high reset
//            key0, key1          raw active-high keys (asynchronous to clk)
//            current_result      ALU result to save
//            calc_busy           ALU mid-operation, saves wait while high
//            memory_result       last saved/recalled value (registered)
//            active_slot         selected slot index (registered)
//            memory_clear        bank cleared and untouched since
//            save_ack/read_ack   one-cycle commit pulses
// Revision : 1.0 - initial release
// ============================================================================
module memory_key_controller #(
  parameter int DATA_W       = 8,
  parameter int NUM_SLOTS    = 4,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int LONG_CYC     = 500000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         key0,
  input  logic                         key1,
  input  logic [DATA_W-1:0]            current_result,
  input  logic                         calc_busy,
  output logic [DATA_W-1:0]            memory_result,
  output logic [$clog2(NUM_SLOTS)-1:0] active_slot,
  output logic                         memory_clear,
  output logic                         save_ack,
  output logic                         read_ack
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W = $clog2(LONG_CYC + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

  // --------------------------------------------------------------------------
  // Key conditioning: 2-flop synchroniser, debouncer, edge detect
  // --------------------------------------------------------------------------
  logic [1:0] raw_keys;
  logic [1:0] key_db;
  logic [1:0] key_press;
  logic [1:0] key_release;

  assign raw_keys = {key1, key0};

  generate
    for (genvar k = 0; k < 2; k++) begin : g_key
      logic            sync_a;
      logic            sync_b;
      logic            level;
      logic            level_d;
      logic [DB_W-1:0] db_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_a  <= 1'b0;
          sync_b  <= 1'b0;
          level   <= 1'b0;
          level_d <= 1'b0;
          db_cnt  <= '0;
        end else begin
          sync_a  <= raw_keys[k];
          sync_b  <= sync_a;
          level_d <= level;
          // The level flips only after DEBOUNCE_CYC consecutive disagreeing
          // samples; a single agreeing sample restarts the count.
          if (sync_b != level) begin
            if (db_cnt == DB_LAST) begin
              level  <= sync_b;
              db_cnt <= '0;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            db_cnt <= '0;
          end
        end
      end

      assign key_db[k]      = level;
      assign key_press[k]   = level & ~level_d;
      assign key_release[k] = ~level & level_d;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Command FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    K0_HOLD   = 3'd1,
    K1_HOLD   = 3'd2,
    SAVE_WAIT = 3'd3,
    WAIT_REL  = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_key;
  logic              hold_last;

  logic do_save;
  logic do_read;
  logic do_adv;
  logic do_clear;

  // The key that owns the current hold state; the other key is ignored.
  assign hold_key  = (state == K1_HOLD) ? key_db[1] : key_db[0];
  // High on the cycle whose closing edge brings the counter to LONG_CYC.
  assign hold_last = hold_key && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    do_save    = 1'b0;
    do_read    = 1'b0;
    do_adv     = 1'b0;
    do_clear   = 1'b0;
    case (state)
      IDLE: begin
        // key0 takes priority when both presses land in the same cycle.
        if (key_press[0]) begin
          state_next = K0_HOLD;
        end else if (key_press[1]) begin
          state_next = K1_HOLD;
        end
      end
      K0_HOLD: begin
        if (key_release[0]) begin
          if (!calc_busy) begin
            do_save    = 1'b1;
            state_next = key_db[1] ? WAIT_REL : IDLE;
          end else begin
            state_next = SAVE_WAIT;
          end
        end else if (hold_last) begin
          do_clear   = 1'b1;
          state_next = WAIT_REL;
        end
      end
      SAVE_WAIT: begin
        if (!calc_busy) begin
          do_save    = 1'b1;
          state_next = key_db[1] ? WAIT_REL : IDLE;
        end
      end
      K1_HOLD: begin
        if (key_release[1]) begin
          do_read    = 1'b1;
          state_next = key_db[0] ? WAIT_REL : IDLE;
        end else if (hold_last) begin
          // key1 is still down here, so a release wait always follows.
          do_adv     = 1'b1;
          state_next = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!key_db[0] && !key_db[1]) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Hold counter: zero outside the hold states, so every hold starts at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state == K0_HOLD || state == K1_HOLD) begin
      if (hold_key && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end else begin
      hold_cnt <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Slot bank and registered outputs
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] slots [NUM_SLOTS];
  logic [SLOT_W-1:0] slot_next;

  // NUM_SLOTS is a power of two, so the natural wrap is the modulo.
  assign slot_next = active_slot + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots[i] <= '0;
      end
      memory_result <= '0;
      active_slot   <= '0;
      memory_clear  <= 1'b0;
      save_ack      <= 1'b0;
      read_ack      <= 1'b0;
    end else begin
      save_ack <= 1'b0;
      read_ack <= 1'b0;
      if (do_clear) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          slots[i] <= '0;
        end
        memory_result <= '0;
        memory_clear  <= 1'b1;
      end else if (do_save) begin
        slots[active_slot] <= current_result;
        memory_result      <= current_result;
        memory_clear       <= 1'b0;
        save_ack           <= 1'b1;
      end else if (do_read) begin
        memory_result <= slots[active_slot];
        memory_clear  <= 1'b0;
        read_ack      <= 1'b1;
      end else if (do_adv) begin
        active_slot   <= slot_next;
        memory_result <= slots[slot_next];
        memory_clear  <= 1'b0;
        read_ack      <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_key_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_memory_key_controller
// Purpose  : Scenario bench for memory_key_controller with a small abstract
//            model of the slot bank (array + selected index + display value).
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_key_controller;

  localparam int DW     = 8;
  localparam int NS     = 4;
  localparam int SW     = 2;
  localparam int DBC    = 4;
  localparam int LC     = 20;
  localparam int SETTLE = 2 + DBC + 6;
  localparam int LONG_LAT = 2 + DBC + 1 + LC;

  logic          clk = 1'b0;
  logic          reset;
  logic          key0;
  logic          key1;
  logic [DW-1:0] current_result;
  logic          calc_busy;
  logic [DW-1:0] memory_result;
  logic [SW-1:0] active_slot;
  logic          memory_clear;
  logic          save_ack;
  logic          read_ack;

  int checks    = 0;
  int failures  = 0;
  int save_cnt  = 0;
  int read_cnt  = 0;

  // Abstract model: what the user should see after each command.
  logic [DW-1:0] m_slot [NS];
  int            m_sel;
  logic [DW-1:0] m_res;
  logic          m_clr;

  logic [DW+SW:0] obs;
  assign obs = {memory_result, active_slot, memory_clear};

  memory_key_controller #(
    .DATA_W      (DW),
    .NUM_SLOTS   (NS),
    .DEBOUNCE_CYC(DBC),
    .LONG_CYC    (LC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key0          (key0),
    .key1          (key1),
    .current_result(current_result),
    .calc_busy     (calc_busy),
    .memory_result (memory_result),
    .active_slot   (active_slot),
    .memory_clear  (memory_clear),
    .save_ack      (save_ack),
    .read_ack      (read_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (save_ack === 1'b1) save_cnt++;
    if (read_ack === 1'b1) read_cnt++;
  end

  // ---------------- model ----------------
  task automatic m_reset();
    for (int i = 0; i < NS; i++) m_slot[i] = '0;
    m_sel = 0; m_res = '0; m_clr = 1'b0;
  endtask

  task automatic m_save(input logic [DW-1:0] v);
    m_slot[m_sel] = v; m_res = v; m_clr = 1'b0;
  endtask

  task automatic m_read();
    m_res = m_slot[m_sel]; m_clr = 1'b0;
  endtask

  task automatic m_adv();
    m_sel = (m_sel + 1) % NS; m_res = m_slot[m_sel]; m_clr = 1'b0;
  endtask

  task automatic m_clear();
    for (int i = 0; i < NS; i++) m_slot[i] = '0;
    m_res = '0; m_clr = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k, input int n);
    @(negedge clk);
    if (k == 0) key0 = 1'b1; else key1 = 1'b1;
    cyc(n);
    if (k == 0) key0 = 1'b0; else key1 = 1'b0;
    cyc(SETTLE);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; key0 = 1'b0; key1 = 1'b0; calc_busy = 1'b0;
    current_result = 8'($urandom_range(1, 255));
    cyc(3);
    reset = 1'b0;
    m_reset();
    cyc(2);
    checks++;
    if ({obs, save_ack, read_ack} !== '0) begin
      failures++;
      $display("FAIL reset_values: got %h required 0", {obs, save_ack, read_ack});
    end
  endtask

  task automatic test_short_save();
    int s0;
    int r0;
    logic [DW-1:0] v;
    for (int it = 0; it < 4; it++) begin
      v = (it == 0) ? 8'h3C : 8'($urandom_range(1, 255));
      s0 = save_cnt; r0 = read_cnt;
      current_result = v;
      press(0, (it == 0) ? 10 : $urandom_range(6, 14));
      m_save(v);
      checks++;
      if (obs !== {m_res, m_sel[SW-1:0], m_clr}) begin
        failures++;
        $display("FAIL short_save[%0d]: got %h required %h", it, obs, {m_res, m_sel[SW-1:0], m_clr});
      end
      checks++;
      if (save_cnt - s0 != 1 || read_cnt != r0) begin
        failures++;
        $display("FAIL short_save_acks[%0d]: got save=%0d read=%0d required save=1 read=0", it, save_cnt - s0, read_cnt - r0);
      end
    end
  endtask

  task automatic test_bounce();
    int s0;
    bit phase;
    s0 = save_cnt;
    phase = 1'($urandom_range(0, 1));
    current_result = 8'($urandom_range(1, 255));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      key0 = phase ^ i[0];
    end
    @(negedge clk);
    key0 = 1'b0;
    cyc(SETTLE);
    checks++;
    if (save_cnt != s0 || obs !== {m_res, m_sel[SW-1:0], m_clr}) begin
      failures++;
      $display("FAIL bounce: got saves=%0d state=%h required saves=0 state=%h", save_cnt - s0, obs, {m_res, m_sel[SW-1:0], m_clr});
    end
  endtask

  task automatic test_busy_save();
    int s0;
    s0 = save_cnt;
    calc_busy = 1'b1;
    current_result = 8'h11;
    press(0, 10);
    cyc(3);
    checks++;
    if (save_cnt != s0 || memory_result !== m_res) begin
      failures++;
      $display("FAIL busy_defer: got saves=%0d result=%h required saves=0 result=%h", save_cnt - s0, memory_result, m_res);
    end
    current_result = 8'h22;
    cyc(1);
    calc_busy = 1'b0;
    @(negedge clk);
    m_save(8'h22);
    checks++;
    if (save_ack !== 1'b1 || memory_result !== 8'h22) begin
      failures++;
      $display("FAIL busy_commit: got ack=%b result=%h required ack=1 result=22", save_ack, memory_result);
    end
    current_result = 8'h77;
    @(negedge clk);
    checks++;
    if (save_ack !== 1'b0 || obs !== {m_res, m_sel[SW-1:0], m_clr}) begin
      failures++;
      $display("FAIL busy_pulse: got ack=%b state=%h required ack=0 state=%h", save_ack, obs, {m_res, m_sel[SW-1:0], m_clr});
    end
  endtask

  task automatic test_slot_advance();
    int  lat;
    bit  seen;
    int  r0;
    current_result = 8'h5A;
    press(0, 10);
    m_save(8'h5A);
    // Long key1 with latency measured from the raw key edge.
    seen = 1'b0; lat = 0;
    @(negedge clk);
    key1 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 26) key1 = 1'b0;
      if (!seen && read_ack === 1'b1) begin
        seen = 1'b1; lat = i;
      end
    end
    cyc(SETTLE);
    m_adv();
    checks++;
    if (!seen || lat < LONG_LAT - 1 || lat > LONG_LAT + 1) begin
      failures++;
      $display("FAIL long_latency: got seen=%0d cycles=%0d required %0d", seen, lat, LONG_LAT);
    end
    checks++;
    if (obs !== {m_res, m_sel[SW-1:0], m_clr}) begin
      failures++;
      $display("FAIL advance_1: got %h required %h", obs, {m_res, m_sel[SW-1:0], m_clr});
    end
    press(1, 10);
    m_read();
    checks++;
    if (obs !== {m_res, m_sel[SW-1:0], m_clr}) begin
      failures++;
      $display("FAIL read_slot1: got %h required %h", obs, {m_res, m_sel[SW-1:0], m_clr});
    end
    for (int i = 0; i < 3; i++) begin
      r0 = read_cnt;
      press(1, 26);
      m_adv();
      checks++;
      if (obs !== {m_res, m_sel[SW-1:0], m_clr} || read_cnt - r0 != 1) begin
        failures++;
        $display("FAIL wrap_%0d: got %h acks=%0d required %h acks=1", i, obs, read_cnt - r0, {m_res, m_sel[SW-1:0], m_clr});
      end
    end
    press(1, 10);
    m_read();
    checks++;
    if (obs !== {m_res, m_sel[SW-1:0], m_clr} || memory_result !== 8'h5A) begin
      failures++;
      $display("FAIL read_after_wrap: got %h required %h", obs, {m_res, m_sel[SW-1:0], m_clr});
    end
  endtask

  task automatic test_clear();
    int s0;
    for (int i = 0; i < NS; i++) begin
      current_result = 8'($urandom_range(1, 255));
      press(0, 10);
      m_save(current_result);
      press(1, 26);
      m_adv();
    end
    s0 = save_cnt;
    press(0, 30);
    m_clear();
    checks++;
    if (obs !== {m_res, m_sel[SW-1:0], m_clr} || save_cnt != s0) begin
      failures++;
      $display("FAIL long_clear: got %h saves=%0d required %h saves=0", obs, save_cnt - s0, {m_res, m_sel[SW-1:0], m_clr});
    end
    for (int i = 0; i < NS; i++) begin
      press(1, 10);
      m_read();
      checks++;
      if (obs !== {m_res, m_sel[SW-1:0], m_clr} || memory_result !== 8'h00) begin
        failures++;
        $display("FAIL cleared_slot%0d: got %h required %h", m_sel, obs, {m_res, m_sel[SW-1:0], m_clr});
      end
      press(1, 26);
      m_adv();
    end
  endtask

  task automatic test_simultaneous();
    int s0;
    int r0;
    s0 = save_cnt; r0 = read_cnt;
    current_result = 8'($urandom_range(1, 255));
    @(negedge clk);
    key0 = 1'b1; key1 = 1'b1;
    cyc(10);
    key0 = 1'b0;
    cyc(20);
    key1 = 1'b0;
    cyc(SETTLE);
    m_save(current_result);
    checks++;
    if (obs !== {m_res, m_sel[SW-1:0], m_clr} || save_cnt - s0 != 1 || read_cnt != r0) begin
      failures++;
      $display("FAIL simultaneous: got %h saves=%0d reads=%0d required %h saves=1 reads=0", obs, save_cnt - s0, read_cnt - r0, {m_res, m_sel[SW-1:0], m_clr});
    end
  endtask

  task automatic test_reset_mid_hold();
    int r0;
    @(negedge clk);
    key0 = 1'b1;
    cyc(12);
    current_result = 8'($urandom_range(1, 255));
    reset = 1'b1;
    key0 = 1'b0;
    cyc(3);
    checks++;
    if ({obs, save_ack, read_ack} !== '0) begin
      failures++;
      $display("FAIL reset_in_hold: got %h required 0", {obs, save_ack, read_ack});
    end
    reset = 1'b0;
    m_reset();
    cyc(SETTLE);
    r0 = read_cnt;
    press(1, 10);
    m_read();
    checks++;
    if (obs !== {m_res, m_sel[SW-1:0], m_clr} || read_cnt - r0 != 1) begin
      failures++;
      $display("FAIL no_write_after_abort: got %h reads=%0d required %h reads=1", obs, read_cnt - r0, {m_res, m_sel[SW-1:0], m_clr});
    end
  endtask

  task automatic test_random_ops();
    int s0;
    int r0;
    int op;
    for (int it = 0; it < 10; it++) begin
      s0 = save_cnt; r0 = read_cnt;
      op = $urandom_range(0, 3);
      current_result = 8'($urandom_range(0, 255));
      case (op)
        0: begin
          calc_busy = 1'b1;
          press(0, $urandom_range(6, 14));
          cyc($urandom_range(0, 4));
          current_result = 8'($urandom_range(0, 255));
          calc_busy = 1'b0;
          cyc(3);
          m_save(current_result);
        end
        1: begin
          press(1, $urandom_range(6, 14));
          m_read();
        end
        2: begin
          press(1, $urandom_range(26, 30));
          m_adv();
        end
        default: begin
          press(0, $urandom_range(6, 14));
          m_save(current_result);
        end
      endcase
      checks++;
      if (obs !== {m_res, m_sel[SW-1:0], m_clr}) begin
        failures++;
        $display("FAIL random_op[%0d] op=%0d: got %h required %h", it, op, obs, {m_res, m_sel[SW-1:0], m_clr});
      end
      checks++;
      if ((save_cnt - s0) != ((op == 0 || op == 3) ? 1 : 0) || (read_cnt - r0) != ((op == 1 || op == 2) ? 1 : 0)) begin
        failures++;
        $display("FAIL random_acks[%0d] op=%0d: got saves=%0d reads=%0d", it, op, save_cnt - s0, read_cnt - r0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_save();
    test_bounce();
    test_busy_save();
    test_slot_advance();
    test_clear();
    test_simultaneous();
    test_reset_mid_hold();
    test_random_ops();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_key_controller.md
# memory_key_controller

Sequences the calculator's result memory from the two user keys. It synchronises and debounces key0/key1 and classifies each press as short or long. It owns a small bank of result slots and schedules saves so they never collide with an in-flight ALU operation. It sits between the board keys, the ALU result bus and the HEX display mux.

## Interface
- DATA_W, 8, width of a stored result (Hex1:Hex0)
- NUM_SLOTS, 4, number of memory slots (power of two, ≥2)
- DEBOUNCE_CYC, 500000, cycles a synchronised key must be stable before its level is accepted (10 ms @ 50 MHz)
- LONG_CYC, 500000000, hold cycles that make a press "long" (10 s @ 50 MHz)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key0  in  1  raw save/clear key, active-high, asynchronous to clk
- key1  in  1  raw read/slot-advance key, active-high, asynchronous to clk
- current_result  in  DATA_W  ALU result to save
- calc_busy  in  1  ALU mid-operation; saves are deferred while high
- memory_result  out  DATA_W  last saved/recalled value for display
- active_slot  out  $clog2(NUM_SLOTS)  currently selected slot
- memory_clear  out  1  level flag: bank cleared, no save/read since
- save_ack  out  1  one-cycle pulse when a save is committed
- read_ack  out  1  one-cycle pulse when a read is committed

## Operation
- Each key passes through a 2-flop synchroniser, then a debouncer. The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYC consecutive cycles. Any bounce restarts the count.
- Press and release events are single-cycle rise and fall detects on the debounced levels.
- The hold counter is $clog2(LONG_CYC+1) bits wide and saturates at LONG_CYC. It is cleared on entry to K0_HOLD or K1_HOLD.
- FSM states: IDLE, K0_HOLD, K1_HOLD, SAVE_WAIT, WAIT_REL.
- IDLE:
  - key0 press -> K0_HOLD.
  - key1 press -> K1_HOLD.
  - Simultaneous presses: key0 wins and key1 is ignored.
- K0_HOLD:
  - Counter increments each cycle while key0 is held.
  - Counter reaches LONG_CYC -> all slots = 0, memory_result = 0, memory_clear = 1 -> WAIT_REL.
  - key0 release before the threshold -> save request. If calc_busy = 0, commit now; otherwise -> SAVE_WAIT.
- SAVE_WAIT: stay while calc_busy = 1. On the first cycle calc_busy = 0, commit the save.
- Save commit:
  - slot[active_slot] = current_result sampled on the commit cycle.
  - memory_result = current_result, memory_clear = 0, save_ack pulse.
  - Next state: WAIT_REL if key1 is held, else IDLE.
- K1_HOLD:
  - key1 release before LONG_CYC -> read commit: memory_result = slot[active_slot], memory_clear = 0, read_ack pulse.
  - Counter reaches LONG_CYC -> active_slot = (active_slot+1) mod NUM_SLOTS, memory_result = slot[new slot], memory_clear = 0, read_ack pulse.
  - Next state: WAIT_REL if either key is still held, else IDLE.
- While in any HOLD state, press events of the other key are ignored.
- WAIT_REL: -> IDLE once both debounced keys are low. No commands execute in this state.
- Reset values: slots = 0, memory_result = 0, active_slot = 0, memory_clear = 0, save_ack = read_ack = 0, state IDLE, debounced levels 0, counters 0.
- Reset asserted mid-hold or mid-SAVE_WAIT aborts the command; nothing is written.

## Timing
- Raw key edge to debounced edge: 2 + DEBOUNCE_CYC cycles for clean input.
- Release event to commit (calc_busy = 0): the register update and ack pulse appear on the clock edge after the fall-detect cycle, i.e. 1 cycle.
- Long press: commit occurs on the edge where the counter hits LONG_CYC, exactly LONG_CYC cycles after the press event. Release afterwards has no further effect.
- SAVE_WAIT: commit 1 cycle after calc_busy is sampled low. The sampled current_result is from that cycle, not from the release cycle.
- All outputs are registered. Acks are high for exactly one cycle per command.

## Test plan
Bench parameters: DEBOUNCE_CYC=4, LONG_CYC=20, NUM_SLOTS=4.
1. Reset, then key0 pulse of 10 cycles with current_result=0x3C and calc_busy=0 -> one save_ack, memory_result=0x3C, slot0=0x3C, memory_clear=0.
2. key0 bouncing (1-cycle glitches) for 12 cycles, then stable low -> no save_ack and memory_result unchanged.
3. Save with calc_busy=1 held for 15 cycles after release, current_result changing 0x11→0x22 while waiting -> save_ack 1 cycle after calc_busy falls, stored value 0x22.
4. Save 0x5A in slot0, then hold key1 for 25 cycles -> active_slot=1 and memory_result=0x00 at cycle 20. Short key1 -> memory_result=0x00. Hold key1 to wrap through 2, 3, 0, then short key1 -> memory_result=0x5A.
5. Slots loaded with nonzero values, then key0 held for 30 cycles -> memory_clear=1 and memory_result=0 from cycle 20; a subsequent read of every slot returns 0x00 and memory_clear drops to 0.
6. key0 and key1 pressed in the same cycle -> save path only. Assert reset during a K0_HOLD -> all outputs return to reset values and no slot is written.
